// File: rtl/excp_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// excp_redirect_ctrl
//
// Purpose:
//   Sequences the pipeline flush and PC redirect that follow a WB-stage
//   exception or ERTN commit. It also produces the masked, registered
//   interrupt request that decode tags onto the next instruction. This block
//   is the only source of flush and redirect in the core.
//
//   Sequence: IDLE -> FLUSH (always exactly one cycle) -> REDIRECT (held
//   until IF accepts) -> IDLE. If IF accepts during the FLUSH cycle, the
//   sequence skips REDIRECT and returns to IDLE at once.
//
// Handshake (redirect_valid / redirect_ready):
//   redirect_valid is high in FLUSH and REDIRECT. While it is high,
//   redirect_pc holds a stable value. A transfer happens on a rising clk edge
//   when redirect_valid and redirect_ready are both high. The state is back
//   to IDLE in the cycle after that edge. Once redirect_valid goes high, it
//   stays high until the transfer completes.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   ws_excp, ws_ertn  WB commits an exception / ERTN this cycle
//   csr_eentry        exception entry address
//   csr_era           ERTN return address
//   csr_crmd_ie       global interrupt enable
//   csr_estat_is      pending interrupt lines
//   csr_ecfg_lie      per-line interrupt enables
//   flush             kill all in-flight instructions in IF..MEM
//   fetch_stall       IF must not issue new fetches
//   redirect_valid    redirect PC offered to IF
//   redirect_pc       redirect target PC
//   redirect_ready    IF accepts the redirect this cycle
//   int_req           interrupt pending; decode tags the next instruction
//   dbg_state         current FSM state (0 IDLE, 1 FLUSH, 2 REDIRECT)
// ---------------------------------------------------------------------------
module excp_redirect_ctrl #(
    parameter int INT_NUM       = 13,
    parameter int ERTN_INT_HOLD = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ws_excp,
    input  logic               ws_ertn,
    input  logic [31:0]        csr_eentry,
    input  logic [31:0]        csr_era,
    input  logic               csr_crmd_ie,
    input  logic [INT_NUM-1:0] csr_estat_is,
    input  logic [INT_NUM-1:0] csr_ecfg_lie,
    output logic               flush,
    output logic               fetch_stall,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    input  logic               redirect_ready,
    output logic               int_req,
    output logic [1:0]         dbg_state
);

    // A hold of 0 still needs a 1-bit counter. With a load value of 0, that
    // counter is always 0, so the hold has no effect.
    localparam int HOLD_W = (ERTN_INT_HOLD > 0) ? $clog2(ERTN_INT_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(ERTN_INT_HOLD);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_seq_ertn;     // current sequence came from an ERTN
    logic [31:0]         r_redirect_pc;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_flush;
    logic                r_fetch_stall;
    logic                r_redirect_valid;
    logic                r_int_req;

    logic                w_start;
    logic                w_seq_done;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                w_flush_nxt;
    logic                w_fetch_stall_nxt;
    logic                w_redirect_valid_nxt;
    logic                w_int_pend;
    logic                w_int_req_nxt;

    // Events that arrive outside IDLE are ignored, because the pipeline is
    // already being flushed.
    assign w_start    = (r_state == S_IDLE) && (ws_excp || ws_ertn);
    assign w_seq_done = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     w_state_nxt = w_start ? S_FLUSH : S_IDLE;
            S_FLUSH:    w_state_nxt = redirect_ready ? S_IDLE : S_REDIRECT;
            S_REDIRECT: w_state_nxt = redirect_ready ? S_IDLE : S_REDIRECT;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----------------
    always_comb begin
        // The hold counter clears when a new sequence starts. It loads only
        // when an ERTN sequence completes. Otherwise it counts down and stops
        // at 0.
        w_hold_nxt = r_hold;
        if (w_start) begin
            w_hold_nxt = '0;
        end else if (w_seq_done && r_seq_ertn) begin
            w_hold_nxt = HOLD_LOAD;
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - HOLD_W'(1);
        end

        // Outputs decode the next state, so they switch on the same edge as
        // the state does. There is no path from ws_* to the ports that
        // bypasses a flop.
        w_flush_nxt          = (w_state_nxt == S_FLUSH);
        w_fetch_stall_nxt    = (w_state_nxt != S_IDLE);
        w_redirect_valid_nxt = (w_state_nxt != S_IDLE);

        w_int_pend    = csr_crmd_ie && (|(csr_estat_is & csr_ecfg_lie));
        // Uses the next hold value, so int_req stays low for the first
        // ERTN_INT_HOLD IDLE cycles after an ERTN redirect.
        w_int_req_nxt = w_int_pend && (w_state_nxt == S_IDLE) && (w_hold_nxt == '0);
    end

    // ---------------- datapath / output registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seq_ertn       <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_hold           <= '0;
            r_flush          <= 1'b0;
            r_fetch_stall    <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_int_req        <= 1'b0;
        end else begin
            if (w_start) begin
                // If both events arrive together, the exception wins.
                r_seq_ertn    <= !ws_excp;
                r_redirect_pc <= ws_excp ? csr_eentry : csr_era;
            end
            r_hold           <= w_hold_nxt;
            r_flush          <= w_flush_nxt;
            r_fetch_stall    <= w_fetch_stall_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_int_req        <= w_int_req_nxt;
        end
    end

    assign flush          = r_flush;
    assign fetch_stall    = r_fetch_stall;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign int_req        = r_int_req;
    assign dbg_state      = r_state;

endmodule
